// File: rtl/line_seq_pkg.sv
// Shared state encoding, default frame geometry and sizing helper for the line frame sequencer.
package line_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2,
        DONE   = 2'd3
    } seq_state_e;

    localparam int LINES_NORMAL_DEF = 1024;
    localparam int LINES_TEST_DEF   = 4;
    localparam int BLANK_CYCLES_DEF = 8;
    localparam int LINE_W_DEF       = 11;
    localparam int WDOG_LIMIT_DEF   = 4200;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int timer_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end else begin
            return $clog2(max_val + 1);
        end
    endfunction

endpackage

// File: rtl/line_frame_sequencer_seq_timer.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module seq_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_r;

    // Load has priority over decrement; the count saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != {W{1'b0}})) begin
            count_r <= count_r - W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/line_frame_sequencer.sv
// Frame sequencer driving the 12-bit line counter: active lines separated by fixed blanks.
// Optional watchdog on the ACTIVE state is built when SEQ_WATCHDOG_EN is defined.
module line_frame_sequencer
    import line_seq_pkg::*;
#(
    parameter int LINES_NORMAL = LINES_NORMAL_DEF,
    parameter int LINES_TEST   = LINES_TEST_DEF,
    parameter int BLANK_CYCLES = BLANK_CYCLES_DEF,
    parameter int LINE_W       = LINE_W_DEF
`ifdef SEQ_WATCHDOG_EN
    ,
    parameter int WDOG_LIMIT   = WDOG_LIMIT_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              test,
    input  logic              end_line,
    output logic              b12_enb,
    output logic              cnt_test,
    output logic [LINE_W-1:0] line_idx,
    output logic              busy,
    output logic              end_frame,
    output logic              err_timeout
);

    localparam int BLANK_W = timer_width(BLANK_CYCLES - 1);
    localparam logic [BLANK_W-1:0] BLANK_LOAD  = BLANK_W'(BLANK_CYCLES - 1);
    localparam logic [LINE_W-1:0]  LAST_NORMAL = LINE_W'(LINES_NORMAL - 1);
    localparam logic [LINE_W-1:0]  LAST_TEST   = LINE_W'(LINES_TEST - 1);

    seq_state_e        state_r;
    seq_state_e        state_nxt_s;
    logic [LINE_W-1:0] line_idx_r;
    logic [LINE_W-1:0] last_idx_s;
    logic              cnt_test_r;
    logic              b12_enb_r;
    logic              busy_r;
    logic              end_frame_r;
    logic              frame_start_s;
    logic              line_inc_s;
    logic              blank_load_s;
    logic              blank_zero_s;

    assign last_idx_s = cnt_test_r ? LAST_TEST : LAST_NORMAL;

    seq_timer #(
        .W(BLANK_W)
    ) u_blank_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (blank_load_s),
        .load_val (BLANK_LOAD),
        .dec      (state_r == BLANK),
        .zero     (blank_zero_s)
    );

`ifdef SEQ_WATCHDOG_EN
    localparam int WDOG_W = timer_width(WDOG_LIMIT - 1);
    localparam logic [WDOG_W-1:0] WDOG_LOAD = WDOG_W'(WDOG_LIMIT - 1);

    logic wdog_load_s;
    logic wdog_zero_s;
    logic timeout_s;
    logic err_timeout_r;

    // Reloaded on every entry to ACTIVE so each line gets a fresh budget.
    assign wdog_load_s = (state_nxt_s == ACTIVE) && (state_r != ACTIVE);

    seq_timer #(
        .W(WDOG_W)
    ) u_wdog_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (wdog_load_s),
        .load_val (WDOG_LOAD),
        .dec      (state_r == ACTIVE),
        .zero     (wdog_zero_s)
    );
`endif

    // Next-state decode; stop overrides every other transition.
    always_comb begin
        state_nxt_s   = state_r;
        frame_start_s = 1'b0;
        line_inc_s    = 1'b0;
        blank_load_s  = 1'b0;
`ifdef SEQ_WATCHDOG_EN
        timeout_s     = 1'b0;
`endif
        if (stop) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_nxt_s   = ACTIVE;
                        frame_start_s = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                ACTIVE: begin
                    if (end_line) begin
                        if (line_idx_r == last_idx_s) begin
                            state_nxt_s = DONE;
                        end else begin
                            state_nxt_s  = BLANK;
                            line_inc_s   = 1'b1;
                            blank_load_s = 1'b1;
                        end
`ifdef SEQ_WATCHDOG_EN
                    end else if (wdog_zero_s) begin
                        state_nxt_s = IDLE;
                        timeout_s   = 1'b1;
`endif
                    end else begin
                        state_nxt_s = ACTIVE;
                    end
                end
                BLANK: begin
                    if (blank_zero_s) begin
                        state_nxt_s = ACTIVE;
                    end else begin
                        state_nxt_s = BLANK;
                    end
                end
                DONE: begin
                    state_nxt_s = IDLE;
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Output flags follow the state being entered, so they are registered yet cycle-aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b12_enb_r   <= 1'b0;
            busy_r      <= 1'b0;
            end_frame_r <= 1'b0;
        end else begin
            b12_enb_r   <= (state_nxt_s == ACTIVE);
            busy_r      <= (state_nxt_s != IDLE);
            end_frame_r <= (state_nxt_s == DONE);
        end
    end

    // Line index and mode are frozen for the frame; the index never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_idx_r <= {LINE_W{1'b0}};
            cnt_test_r <= 1'b0;
        end else if (stop || frame_start_s) begin
            line_idx_r <= {LINE_W{1'b0}};
            cnt_test_r <= frame_start_s ? test : cnt_test_r;
        end else if (line_inc_s) begin
            line_idx_r <= line_idx_r + LINE_W'(1);
            cnt_test_r <= cnt_test_r;
        end else begin
            line_idx_r <= line_idx_r;
            cnt_test_r <= cnt_test_r;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    // Sticky timeout flag, cleared only by the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_timeout_r <= 1'b0;
        end else if (frame_start_s) begin
            err_timeout_r <= 1'b0;
        end else if (timeout_s) begin
            err_timeout_r <= 1'b1;
        end else begin
            err_timeout_r <= err_timeout_r;
        end
    end

    assign err_timeout = err_timeout_r;
`else
    assign err_timeout = 1'b0;
`endif

    assign b12_enb   = b12_enb_r;
    assign busy      = busy_r;
    assign end_frame = end_frame_r;
    assign line_idx  = line_idx_r;
    assign cnt_test  = cnt_test_r;

endmodule

// File: tb/tb_line_frame_sequencer.sv
// Bench for line_frame_sequencer paired with a 12-bit line counter (terminal 1289 / 4095 by cnt_test).
module tb_line_frame_sequencer;

    localparam int LN     = 2;
    localparam int LT     = 4;
    localparam int BLANK  = 8;
    localparam int LINE_W = 11;
    localparam int TERM_N = 1289;
    localparam int TERM_T = 4095;
    localparam int WDOG   = 4200;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              test = 1'b0;
    logic              end_line;
    logic              b12_enb;
    logic              cnt_test;
    logic [LINE_W-1:0] line_idx;
    logic              busy;
    logic              end_frame;
    logic              err_timeout;
    logic [11:0]       lc_cnt;
    logic              force_low = 1'b0;

    int checks = 0;
    int errors = 0;

    always #8 clk = ~clk;

    line_frame_sequencer #(
        .LINES_NORMAL (LN),
        .LINES_TEST   (LT),
        .BLANK_CYCLES (BLANK),
        .LINE_W       (LINE_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .test        (test),
        .end_line    (end_line),
        .b12_enb     (b12_enb),
        .cnt_test    (cnt_test),
        .line_idx    (line_idx),
        .busy        (busy),
        .end_frame   (end_frame),
        .err_timeout (err_timeout)
    );

    // Line counter: counts while enabled, cleared while enable is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lc_cnt <= 12'd0;
        else if (!b12_enb) lc_cnt <= 12'd0;
        else lc_cnt <= lc_cnt + 12'd1;
    end

    assign end_line = !force_low && (lc_cnt == (cnt_test ? 12'(TERM_T) : 12'(TERM_N)));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int frame_end_of(input logic mode);
        int n;
        int period;
        n      = mode ? LT : LN;
        period = (mode ? TERM_T : TERM_N) + 1 + BLANK;
        return n * period - BLANK;
    endfunction

    // Expected outputs at cycle t after the accepted start, from the frame geometry.
    function automatic void expect_at(input int t, input logic mode, input int stop_at,
                                      output logic e_enb, output int e_idx,
                                      output logic e_ef, output logic e_busy);
        int n;
        int term;
        int period;
        int fend;
        n      = mode ? LT : LN;
        term   = mode ? TERM_T : TERM_N;
        period = term + 1 + BLANK;
        fend   = n * period - BLANK;
        if (stop_at >= 0 && t > stop_at) begin
            e_enb = 1'b0; e_idx = 0; e_ef = 1'b0; e_busy = 1'b0;
        end else if (t < fend) begin
            e_ef = 1'b0; e_busy = 1'b1;
            if ((t % period) <= term) begin
                e_enb = 1'b1; e_idx = t / period;
            end else begin
                e_enb = 1'b0; e_idx = t / period + 1;
            end
        end else if (t == fend) begin
            e_enb = 1'b0; e_idx = n - 1; e_ef = 1'b1; e_busy = 1'b1;
        end else begin
            e_enb = 1'b0; e_idx = n - 1; e_ef = 1'b0; e_busy = 1'b0;
        end
    endfunction

    task automatic run_frame(input string name, input logic mode, input int stop_at, input bit jitter);
        int   total;
        int   mm_enb, mm_idx, mm_busy, mm_test, mm_err, ef_seen, ef_exp;
        int   fb_enb, fb_idx, fb_busy;
        logic e_enb, e_ef, e_busy;
        int   e_idx;
        mm_enb = 0; mm_idx = 0; mm_busy = 0; mm_test = 0; mm_err = 0; ef_seen = 0; ef_exp = 0;
        fb_enb = -1; fb_idx = -1; fb_busy = -1;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        start = 1'b1;
        test  = mode;
        stop  = 1'b0;
        total = (stop_at >= 0) ? stop_at + 4 : frame_end_of(mode) + 4;
        for (int t = 0; t < total; t++) begin
            @(negedge clk);
            expect_at(t, mode, stop_at, e_enb, e_idx, e_ef, e_busy);
            if (b12_enb !== e_enb) begin mm_enb++; if (fb_enb < 0) fb_enb = t; end
            if (line_idx !== LINE_W'(e_idx)) begin mm_idx++; if (fb_idx < 0) fb_idx = t; end
            if (busy !== e_busy) begin mm_busy++; if (fb_busy < 0) fb_busy = t; end
            if (e_busy && (cnt_test !== mode)) mm_test++;
            if (err_timeout !== 1'b0) mm_err++;
            if (end_frame === 1'b1) ef_seen++;
            if (end_frame !== e_ef) mm_busy++;
            if (e_ef) ef_exp++;
            stop = (t == stop_at);
            if (jitter && e_busy && (stop_at < 0 || t <= stop_at)) begin
                start = 1'($urandom_range(0, 1));
                test  = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
                test  = mode;
            end
        end
        stop  = 1'b0;
        start = 1'b0;
        check($sformatf("%s_enb_trace(first_bad=%0d)", name, fb_enb), mm_enb, 0);
        check($sformatf("%s_idx_trace(first_bad=%0d)", name, fb_idx), mm_idx, 0);
        check($sformatf("%s_busy_ef_trace(first_bad=%0d)", name, fb_busy), mm_busy, 0);
        check($sformatf("%s_cnt_test_frozen", name), mm_test, 0);
        check($sformatf("%s_err_clear", name), mm_err, 0);
        check($sformatf("%s_end_frame_count", name), ef_seen, ef_exp);
    endtask

    initial begin
        int   mm_act, mm_err;
        logic exp_act, exp_err;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_b12_enb", b12_enb, 0);
        check("rst_cnt_test", cnt_test, 0);
        check("rst_line_idx", line_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_end_frame", end_frame, 0);
        check("rst_err_timeout", err_timeout, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame("t1_test_mode", 1'b1, -1, 1'b0);
        run_frame("t2_normal", 1'b0, -1, 1'b0);
        run_frame("t3_stop_blank", 1'b0, TERM_N + 1 + int'($urandom_range(0, BLANK - 1)), 1'b0);
        run_frame("t3_restart", 1'b0, -1, 1'b0);
        run_frame("t4_stop_last_line", 1'b0, frame_end_of(1'b0) - 1, 1'b0);
        run_frame("t5_jitter", 1'b0, -1, 1'b1);

        // Watchdog: end_line held low for longer than the limit
        mm_act = 0; mm_err = 0;
        @(negedge clk);
        force_low = 1'b1;
        start = 1'b1;
        test  = 1'b1;
        for (int t = 0; t < WDOG + 100; t++) begin
            @(negedge clk);
            start = 1'b0;
`ifdef SEQ_WATCHDOG_EN
            exp_act = (t < WDOG);
            exp_err = (t >= WDOG);
`else
            exp_act = 1'b1;
            exp_err = 1'b0;
`endif
            if (b12_enb !== exp_act || busy !== exp_act) mm_act++;
            if (err_timeout !== exp_err) mm_err++;
        end
        check("t6_wdog_active_trace", mm_act, 0);
        check("t6_wdog_err_trace", mm_err, 0);
        force_low = 1'b0;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
        check("t6_after_stop_busy", busy, 0);
        check("t6_after_stop_enb", b12_enb, 0);
`ifdef SEQ_WATCHDOG_EN
        check("t6_err_sticky", err_timeout, 1);
`else
        check("t6_err_sticky", err_timeout, 0);
`endif
        run_frame("t6_restart", 1'b0, -1, 1'b0);

        for (int i = 0; i < 3; i++) begin
            int sa;
            sa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, frame_end_of(1'b0))) : -1;
            run_frame($sformatf("rand%0d", i), 1'b0, sa, 1'b1);
        end

        // Reset asserted mid-frame
        @(negedge clk);
        start = 1'b1;
        test  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4200) @(negedge clk);
        check("midrst_pre_idx", line_idx, 1);
        check("midrst_pre_cnt_test", cnt_test, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_b12_enb", b12_enb, 0);
        check("midrst_cnt_test", cnt_test, 0);
        check("midrst_line_idx", line_idx, 0);
        check("midrst_busy", busy, 0);
        check("midrst_end_frame", end_frame, 0);
        check("midrst_err_timeout", err_timeout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
